segasys1_vram_arbiter: RTL and testbench
========================================

SEGASYS1_VRAM_ARBITER -- requirements
Module: segasys1_vram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 11, meaning video RAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning video RAM data width.
REQ-003 SHALL have parameter STARVE, default 4, meaning consecutive lost arbitrations after which the CPU wins (range 1..15).
REQ-004 SHALL have ports: CLK48M  in  1  sole clock, all logic on rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 CPU_RQ, CPU_WE  in  1 each  CPU request, CPU write enable; CPU_AD in AW; CPU_DI in DW.
REQ-007 BG_RQ  in  1  BG tile fetch request (read only); BG_AD in AW.
REQ-008 SP_RQ  in  1  sprite fetch request (read only); SP_AD in AW.
REQ-009 CPU_ACK, BG_ACK, SP_ACK  out  1 each  one-cycle completion pulse per requester.
REQ-010 RDATA  out  DW  read data, shared, valid in the ACK cycle.
REQ-011 CPU_WAIT  out  1  CPU stall, combinational CPU_RQ & ~CPU_ACK.
REQ-012 RAM_AD out AW, RAM_DO out DW, RAM_WE out 1, RAM_EN out 1  registered RAM drive; RAM_DI in DW  RAM read data, one-cycle synchronous latency.
REQ-013 BUSY  out  1  high whenever FSM not IDLE; GNT  out  2  current owner (0 none, 1 BG, 2 SP, 3 CPU).

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, CAPT; transitions IDLE->ISSUE on any request, ISSUE->CAPT always, CAPT->IDLE always.
REQ-015 Requests SHALL be sampled only in IDLE; requests rising in ISSUE/CAPT wait for next IDLE.
REQ-016 Priority in IDLE SHALL be BG > SP > CPU, except CPU wins when the starvation counter equals STARVE and CPU_RQ is high.
REQ-017 On a win in IDLE the arbiter SHALL latch winner's address, CPU_DI and CPU_WE (CPU_WE forced 0 for BG/SP) and set GNT.
REQ-018 In ISSUE, RAM_EN SHALL be 1, RAM_AD/RAM_DO carry latched values, RAM_WE equals latched write flag; RAM_EN and RAM_WE SHALL be 0 in every other state.
REQ-019 In CAPT, RDATA SHALL register RAM_DI (held for writes as RAM read-during-write value) and the winner's ACK SHALL pulse exactly one cycle.
REQ-020 Latency: request seen in IDLE at edge N -> ACK high in cycle N+2; max throughput one access per 3 cycles.
REQ-021 RDATA SHALL hold its value between ACKs.
REQ-022 Requesters SHALL hold RQ, address and data stable until ACK; an RQ still high in the cycle after ACK SHALL be treated as a new transaction.
REQ-023 Starvation counter (4 bits, saturating at STARVE) SHALL increment on each IDLE decision where CPU_RQ is high and CPU loses; clear when CPU is granted or CPU_RQ is low in IDLE.
REQ-024 Simultaneous BG_RQ, SP_RQ, CPU_RQ with counter below STARVE: BG SHALL win.
REQ-025 A requester dropping RQ before ACK (protocol violation) SHALL NOT abort the access; ACK SHALL still pulse.
REQ-026 GNT SHALL return to 0 on the CAPT->IDLE transition; BUSY SHALL be 0 only in IDLE.

Reset
REQ-027 RESET high SHALL asynchronously force IDLE, all ACKs 0, RAM_EN 0, RAM_WE 0, RAM_AD 0, RAM_DO 0, RDATA 0, GNT 0, BUSY 0, starvation counter 0.
REQ-028 Reset during ISSUE SHALL abort the write (RAM_WE drops immediately) and no ACK SHALL be issued for the aborted access.
REQ-029 After RESET deasserts, first arbitration SHALL occur at the first rising edge with FSM in IDLE.

Verification
REQ-030 Single CPU write CPU_AD=0x123, CPU_DI=0x5A -> RAM_EN=RAM_WE=1, RAM_AD=0x123, RAM_DO=0x5A in ISSUE; CPU_ACK pulse two cycles after sample; CPU_WAIT low in ACK cycle.
REQ-031 BG read at 0x040 with RAM holding 0xA7 -> BG_ACK at N+2 with RDATA=0xA7, RAM_WE=0 throughout.
REQ-032 BG_RQ, SP_RQ, CPU_RQ asserted together and held (re-asserted after each ACK) -> grant order BG,BG,BG,BG,CPU with STARVE=4; counter cleared after CPU grant.
REQ-033 SP_RQ and CPU_RQ simultaneous, BG idle -> SP granted first, CPU next IDLE; CPU_WAIT high until CPU_ACK.
REQ-034 RESET asserted mid-ISSUE of CPU write -> RAM_WE and RAM_EN 0 same cycle, no CPU_ACK, BUSY 0; after release with CPU_RQ held, write reissued and acknowledged.
REQ-035 Back-to-back BG requests with RQ held high -> ACK every 3 cycles, no missed or duplicated ACK over 100 accesses.

Source files
------------

// File: rtl/segasys1_vram_arbiter.sv
// Three-requester (BG > SP > CPU, CPU anti-starvation) arbiter for one synchronous video RAM.
// One access per 3 cycles; ACK two cycles after the IDLE sample; losers simply wait with RQ held.
module segasys1_vram_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int STARVE = 4
) (
    input  logic          CLK48M,
    input  logic          RESET,
    input  logic          CPU_RQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_AD,
    input  logic [DW-1:0] CPU_DI,
    input  logic          BG_RQ,
    input  logic [AW-1:0] BG_AD,
    input  logic          SP_RQ,
    input  logic [AW-1:0] SP_AD,
    output logic          CPU_ACK,
    output logic          BG_ACK,
    output logic          SP_ACK,
    output logic [DW-1:0] RDATA,
    output logic          CPU_WAIT,
    output logic [AW-1:0] RAM_AD,
    output logic [DW-1:0] RAM_DO,
    output logic          RAM_WE,
    output logic          RAM_EN,
    input  logic [DW-1:0] RAM_DI,
    output logic          BUSY,
    output logic [1:0]    GNT
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_BG   = 2'd1;
    localparam logic [1:0] G_SP   = 2'd2;
    localparam logic [1:0] G_CPU  = 2'd3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    state_t          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            ram_en_q, ram_en_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_ad_q, ram_ad_d;
    logic [DW-1:0]   ram_do_q, ram_do_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      ack_q, ack_d;   // {cpu, sp, bg}
    logic [1:0]      win;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        ram_ad_d = ram_ad_q;
        ram_do_d = ram_do_q;
        rdata_d  = rdata_q;
        ack_d    = 3'b000;
        win      = G_NONE;

        case (state_q)
            S_IDLE: begin
                if (CPU_RQ && starve_q == STARVE_LIM) win = G_CPU;
                else if (BG_RQ)                        win = G_BG;
                else if (SP_RQ)                        win = G_SP;
                else if (CPU_RQ)                       win = G_CPU;

                if (!CPU_RQ || win == G_CPU)    starve_d = 4'd0;
                else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;

                if (win != G_NONE) begin
                    state_d  = S_ISSUE;
                    gnt_d    = win;
                    busy_d   = 1'b1;
                    ram_en_d = 1'b1;
                    ram_we_d = (win == G_CPU) && CPU_WE;
                    ram_do_d = CPU_DI;
                    case (win)
                        G_BG:    ram_ad_d = BG_AD;
                        G_SP:    ram_ad_d = SP_AD;
                        default: ram_ad_d = CPU_AD;
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                // RAM data for the ISSUE-cycle address is valid now (one-cycle RAM latency).
                state_d = S_IDLE;
                rdata_d = RAM_DI;
                ack_d   = {gnt_q == G_CPU, gnt_q == G_SP, gnt_q == G_BG};
                gnt_d   = G_NONE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = G_NONE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            starve_q <= 4'd0;
            gnt_q    <= G_NONE;
            busy_q   <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            ram_ad_q <= '0;
            ram_do_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
            ram_ad_q <= ram_ad_d;
            ram_do_q <= ram_do_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
        end
    end

    assign BG_ACK   = ack_q[0];
    assign SP_ACK   = ack_q[1];
    assign CPU_ACK  = ack_q[2];
    assign RDATA    = rdata_q;
    assign CPU_WAIT = CPU_RQ & ~ack_q[2];
    assign RAM_AD   = ram_ad_q;
    assign RAM_DO   = ram_do_q;
    assign RAM_WE   = ram_we_q;
    assign RAM_EN   = ram_en_q;
    assign BUSY     = busy_q;
    assign GNT      = gnt_q;

endmodule

// File: tb/tb_segasys1_vram_arbiter.sv
// Bench for segasys1_vram_arbiter: transaction-level model plus directed scenarios.
module tb_segasys1_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int STARVE = 4;

    logic          CLK48M = 1'b0;
    logic          RESET  = 1'b1;
    logic          CPU_RQ = 1'b0, CPU_WE = 1'b0;
    logic [AW-1:0] CPU_AD = '0;
    logic [DW-1:0] CPU_DI = '0;
    logic          BG_RQ  = 1'b0;
    logic [AW-1:0] BG_AD  = '0;
    logic          SP_RQ  = 1'b0;
    logic [AW-1:0] SP_AD  = '0;
    logic          CPU_ACK, BG_ACK, SP_ACK, CPU_WAIT, RAM_WE, RAM_EN, BUSY;
    logic [DW-1:0] RDATA, RAM_DO;
    logic [DW-1:0] RAM_DI = '0;
    logic [AW-1:0] RAM_AD;
    logic [1:0]    GNT;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    segasys1_vram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .CLK48M(CLK48M), .RESET(RESET),
        .CPU_RQ(CPU_RQ), .CPU_WE(CPU_WE), .CPU_AD(CPU_AD), .CPU_DI(CPU_DI),
        .BG_RQ(BG_RQ), .BG_AD(BG_AD), .SP_RQ(SP_RQ), .SP_AD(SP_AD),
        .CPU_ACK(CPU_ACK), .BG_ACK(BG_ACK), .SP_ACK(SP_ACK),
        .RDATA(RDATA), .CPU_WAIT(CPU_WAIT),
        .RAM_AD(RAM_AD), .RAM_DO(RAM_DO), .RAM_WE(RAM_WE), .RAM_EN(RAM_EN),
        .RAM_DI(RAM_DI), .BUSY(BUSY), .GNT(GNT)
    );

    always #5 CLK48M = ~CLK48M;

    initial forever begin
        @(posedge CLK48M);
        cyc_cnt++;
    end

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 'h040) return 8'hA7;
        return DW'((a * 37 + 11) & 255);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous read-first RAM driven by the DUT.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_rd;
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
        forever begin
            @(posedge CLK48M);
            if (RAM_EN) begin
                ram_rd = ram[RAM_AD];
                if (RAM_WE) ram[RAM_AD] = RAM_DO;
                RAM_DI <= ram_rd;
            end
        end
    end

    // Transaction model: each granted access occupies three cycles (issue, capture, ack).
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            ph = 0, m_starve = 0, m_win = 0, e_who = 0;
    logic [AW-1:0] m_ad = '0;
    logic [DW-1:0] m_do = '0, m_rd = '0;
    logic          m_we = 1'b0;
    logic          e_en = 1'b0, e_we = 1'b0, e_busy = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic [1:0]    e_gnt = '0;

    function automatic int pick(bit bg, bit sp, bit cpu, int starve);
        if (cpu && starve >= STARVE) return 3;
        if (bg)  return 1;
        if (sp)  return 2;
        if (cpu) return 3;
        return 0;
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
        forever begin
            @(posedge CLK48M);
            if (RESET) begin
                ph = 0; m_starve = 0; e_who = 0;
                e_en = 0; e_we = 0; e_busy = 0; e_rdata = '0; e_gnt = '0;
            end else if (ph == 0) begin
                e_who = 0;
                m_win = pick(BG_RQ, SP_RQ, CPU_RQ, m_starve);
                if (!CPU_RQ || m_win == 3) m_starve = 0;
                else if (m_starve < STARVE) m_starve++;
                if (m_win != 0) begin
                    m_ad = (m_win == 1) ? BG_AD : (m_win == 2) ? SP_AD : CPU_AD;
                    m_we = (m_win == 3) && CPU_WE;
                    m_do = CPU_DI;
                    e_en = 1; e_we = m_we; e_gnt = 2'(m_win); e_busy = 1;
                    ph = 1;
                end
            end else if (ph == 1) begin
                m_rd = shadow[m_ad];
                if (m_we) shadow[m_ad] = m_do;
                e_en = 0; e_we = 0;
                ph = 2;
            end else begin
                e_rdata = m_rd; e_who = m_win; e_gnt = '0; e_busy = 0;
                ph = 0;
            end
        end
    end

    initial forever begin
        @(posedge CLK48M);
        #2;
        check("bg_ack",   32'(BG_ACK),   32'(e_who == 1));
        check("sp_ack",   32'(SP_ACK),   32'(e_who == 2));
        check("cpu_ack",  32'(CPU_ACK),  32'(e_who == 3));
        check("rdata",    32'(RDATA),    32'(e_rdata));
        check("ram_en",   32'(RAM_EN),   32'(e_en));
        check("ram_we",   32'(RAM_WE),   32'(e_we));
        check("gnt",      32'(GNT),      32'(e_gnt));
        check("busy",     32'(BUSY),     32'(e_busy));
        check("cpu_wait", 32'(CPU_WAIT), 32'(CPU_RQ && e_who != 3));
        if (e_en) begin
            check("ram_ad", 32'(RAM_AD), 32'(m_ad));
            check("ram_do", 32'(RAM_DO), 32'(m_do));
        end
    end

    task automatic wait_ack(output int who);
        who = 0;
        for (int k = 0; k < 12 && who == 0; k++) begin
            @(posedge CLK48M);
            #1;
            if (BG_ACK)       who = 1;
            else if (SP_ACK)  who = 2;
            else if (CPU_ACK) who = 3;
        end
        if (who == 0) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got none, expected an ACK within 12 cycles at %0t", $time);
        end
    endtask

    int who;
    int prev_cyc;

    initial begin
        #2;
        check("rst_ack",    32'({CPU_ACK, SP_ACK, BG_ACK}), 32'h0);
        check("rst_ram_en", 32'(RAM_EN), 32'h0);
        check("rst_ram_we", 32'(RAM_WE), 32'h0);
        check("rst_ram_ad", 32'(RAM_AD), 32'h0);
        check("rst_ram_do", 32'(RAM_DO), 32'h0);
        check("rst_rdata",  32'(RDATA),  32'h0);
        check("rst_gnt",    32'(GNT),    32'h0);
        check("rst_busy",   32'(BUSY),   32'h0);
        repeat (2) @(negedge CLK48M);
        RESET = 0;
        @(negedge CLK48M);

        // Single CPU write
        CPU_RQ = 1; CPU_WE = 1; CPU_AD = 11'h123; CPU_DI = 8'h5A;
        @(posedge CLK48M); #1;
        check("wr_issue_en", 32'(RAM_EN), 32'h1);
        check("wr_issue_we", 32'(RAM_WE), 32'h1);
        check("wr_issue_ad", 32'(RAM_AD), 32'h123);
        check("wr_issue_do", 32'(RAM_DO), 32'h5A);
        check("wr_issue_gnt", 32'(GNT), 32'h3);
        @(posedge CLK48M); #1;
        check("wr_capt_noack", 32'(CPU_ACK), 32'h0);
        @(posedge CLK48M); #1;
        check("wr_ack", 32'(CPU_ACK), 32'h1);
        check("wr_ack_wait", 32'(CPU_WAIT), 32'h0);
        CPU_RQ = 0; CPU_WE = 0;
        check("wr_ram_123", 32'(ram[11'h123]), 32'h5A);
        @(negedge CLK48M);

        // BG read of a known location
        BG_RQ = 1; BG_AD = 11'h040;
        @(posedge CLK48M); #1;
        check("bg_issue_we", 32'(RAM_WE), 32'h0);
        check("bg_issue_ad", 32'(RAM_AD), 32'h040);
        check("bg_issue_gnt", 32'(GNT), 32'h1);
        @(posedge CLK48M); #1;
        check("bg_capt_we", 32'(RAM_WE), 32'h0);
        @(posedge CLK48M); #1;
        check("bg_ack", 32'(BG_ACK), 32'h1);
        check("bg_rdata", 32'(RDATA), 32'hA7);
        BG_RQ = 0;
        repeat (2) @(negedge CLK48M);
        check("rdata_hold", 32'(RDATA), 32'hA7);

        // All three held: four BG grants then the starved CPU, twice
        BG_AD = 11'h011; SP_AD = 11'h022; CPU_AD = 11'h033; CPU_WE = 0;
        BG_RQ = 1; SP_RQ = 1; CPU_RQ = 1;
        for (int i = 0; i < 10; i++) begin
            wait_ack(who);
            check("starve_order", 32'(who), (i % 5 == 4) ? 32'h3 : 32'h1);
        end
        BG_RQ = 0; SP_RQ = 0; CPU_RQ = 0;
        @(negedge CLK48M);

        // SP and CPU together
        SP_RQ = 1; CPU_RQ = 1; SP_AD = 11'h055; CPU_AD = 11'h066;
        wait_ack(who);
        check("sp_first", 32'(who), 32'h2);
        check("cpu_wait_sp", 32'(CPU_WAIT), 32'h1);
        SP_RQ = 0;
        wait_ack(who);
        check("cpu_second", 32'(who), 32'h3);
        CPU_RQ = 0;
        @(negedge CLK48M);

        // Reset in the middle of a CPU write
        CPU_RQ = 1; CPU_WE = 1; CPU_AD = 11'h2AA; CPU_DI = 8'h3C;
        @(posedge CLK48M); #1;
        check("rst_wr_issue", 32'(RAM_WE), 32'h1);
        #2;
        RESET = 1;
        #1;
        check("rst_mid_we",   32'(RAM_WE),  32'h0);
        check("rst_mid_en",   32'(RAM_EN),  32'h0);
        check("rst_mid_busy", 32'(BUSY),    32'h0);
        check("rst_mid_ack",  32'(CPU_ACK), 32'h0);
        repeat (2) @(posedge CLK48M);
        #1;
        check("rst_no_ack", 32'(CPU_ACK), 32'h0);
        check("rst_no_write", 32'(ram[11'h2AA]), 32'(init_val('h2AA)));
        @(negedge CLK48M);
        RESET = 0;
        wait_ack(who);
        check("rst_reissue", 32'(who), 32'h3);
        check("rst_wr_done", 32'(ram[11'h2AA]), 32'h3C);
        CPU_RQ = 0; CPU_WE = 0;
        @(negedge CLK48M);

        // Back-to-back BG, 100 accesses, ACK every third cycle
        BG_RQ = 1; BG_AD = 11'h100;
        prev_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            wait_ack(who);
            check("b2b_who", 32'(who), 32'h1);
            if (i > 0) check("b2b_spacing", 32'(cyc_cnt - prev_cyc), 32'h3);
            prev_cyc = cyc_cnt;
        end
        BG_RQ = 0;
        repeat (4) @(negedge CLK48M);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
